// File: rtl/fifo_burst_reader_pkg.sv
// rtl/fifo_burst_reader_pkg.sv - shared state encoding and skid sizing for fifo_burst_reader
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SKID_DEPTH    = 2;
  localparam int SKID_CNT_BITS = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_stream_skid2.sv
// rtl/fifo_burst_reader_stream_skid2.sv - two-entry in-order skid buffer
module stream_skid2
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [SKID_CNT_BITS-1:0] count
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;

  assign head_data = entry0;

  // entry0 is always the head; a pop shifts entry1 forward
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) entry0 <= push_data;
          else             entry1 <= push_data;
          count <= count + SKID_CNT_BITS'(1);
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - SKID_CNT_BITS'(1);
        end
        2'b11: begin
          if (count == SKID_CNT_BITS'(1)) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops a fixed-length burst from a show-ahead FIFO onto a valid/ready stream
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int BURST_LEN = 8,
  localparam int CNT_BITS  = $clog2(BURST_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    fifo_rdata,
  input  logic                fifo_is_empty,
  output logic                fifo_ren,
  input  logic                start,
  input  logic                abort,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [CNT_BITS-1:0] words_sent
);

  localparam logic [CNT_BITS-1:0] LEN    = CNT_BITS'(BURST_LEN);
  localparam logic [CNT_BITS-1:0] LEN_M1 = CNT_BITS'(BURST_LEN - 1);

  state_t                   state;
  state_t                   state_nx;
  logic [CNT_BITS-1:0]      fetch;
  logic                     abort_seen;
  logic [SKID_CNT_BITS-1:0] skid_count;
  logic [WIDTH:0]           skid_head;
  logic                     fetch_last;
  logic                     xfer;
  logic                     launch;

  assign fetch_last = (fetch == LEN_M1);
  assign out_valid  = (skid_count != '0);
  assign out_data   = skid_head[WIDTH-1:0];
  assign out_last   = out_valid & skid_head[WIDTH];
  assign xfer       = out_valid & out_ready;
  assign busy       = (state != ST_IDLE);
  assign aborted    = done & abort_seen;
  assign launch     = (state == ST_IDLE) & start & ~abort;

  always_comb begin
    state_nx = state;
    fifo_ren = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) state_nx = ST_RUN;
      end
      ST_RUN: begin
        fifo_ren = !fifo_is_empty && (fetch < LEN) &&
                   (skid_count < SKID_CNT_BITS'(SKID_DEPTH)) && !abort;
        if (abort || (fetch == LEN) || (fifo_ren && fetch_last)) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (skid_count == '0) begin
          state_nx = ST_IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fetch      <= '0;
      words_sent <= '0;
      abort_seen <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        fetch      <= '0;
        words_sent <= '0;
        abort_seen <= 1'b0;
      end else begin
        if (fifo_ren) fetch <= fetch + CNT_BITS'(1);
        if (xfer)     words_sent <= words_sent + CNT_BITS'(1);
        if (state == ST_RUN && abort) abort_seen <= 1'b1;
      end
    end
  end

  // last tag travels with the word so the stream side needs no counter compare
  stream_skid2 #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_ren),
    .push_data ({fetch_last, fifo_rdata}),
    .pop       (xfer),
    .head_data (skid_head),
    .count     (skid_count)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - randomized self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

  localparam int W = 16;
  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort, out_ready, flush, mon_clr;
  logic [W-1:0] fifo_rdata, out_data;
  logic         fifo_is_empty, fifo_ren, out_valid, out_last, busy, done, aborted;
  logic [2:0]   words_sent;

  logic         start1, abort1, ready1, clr1;
  logic [W-1:0] fifo1_rdata, out_data1;
  logic         fifo1_is_empty, fifo1_ren, out_valid1, out_last1, busy1, done1, aborted1;
  logic [0:0]   ws1;

  fifo_burst_reader #(.WIDTH(W), .BURST_LEN(L)) dut (
    .clk(clk), .rst(rst), .fifo_rdata(fifo_rdata), .fifo_is_empty(fifo_is_empty),
    .fifo_ren(fifo_ren), .start(start), .abort(abort), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .done(done), .aborted(aborted), .words_sent(words_sent)
  );

  fifo_burst_reader #(.WIDTH(W), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_rdata(fifo1_rdata), .fifo_is_empty(fifo1_is_empty),
    .fifo_ren(fifo1_ren), .start(start1), .abort(abort1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(ready1), .out_last(out_last1), .busy(busy1),
    .done(done1), .aborted(aborted1), .words_sent(ws1)
  );

  // show-ahead FIFO models; ref queues hold what the bench believes is still inside
  logic [W-1:0] mem [0:1023];
  logic [W-1:0] mem1 [0:15];
  int wr_ptr = 0, rd_ptr = 0, wr1 = 0, rd1 = 0;
  logic [W-1:0] ref_q[$];
  logic [W-1:0] ref1_q[$];

  assign fifo_rdata     = mem[rd_ptr[9:0]];
  assign fifo_is_empty  = (rd_ptr == wr_ptr);
  assign fifo1_rdata    = mem1[rd1[3:0]];
  assign fifo1_is_empty = (rd1 == wr1);

  always @(posedge clk) begin
    if (flush)         rd_ptr <= wr_ptr;
    else if (fifo_ren) rd_ptr <= rd_ptr + 1;
    if (fifo1_ren)     rd1 <= rd1 + 1;
  end

  logic [W-1:0] got_d[$];
  logic         got_l[$];
  int           got_c[$];
  logic [W-1:0] got1_d[$];
  logic         got1_l[$];
  int mon_cyc = 0, done_cnt = 0, hold_viol = 0, empty_viol = 0, done1_cnt = 0;
  logic last_ab = 1'b0, ab1 = 1'b0, prev_stall = 1'b0;
  logic [W:0]  prev_word = '0;
  logic [15:0] ren_vec = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      got_d.delete(); got_l.delete(); got_c.delete();
      mon_cyc = 0;
      ren_vec = '0;
    end
    if (rst === 1'b0) begin
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last); got_c.push_back(mon_cyc);
      end
      if (done) begin done_cnt++; last_ab = aborted; end
      if (fifo_ren && fifo_is_empty) empty_viol++;
      if (prev_stall && (!out_valid || {out_last, out_data} != prev_word)) hold_viol++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end else begin
      prev_stall = 1'b0;
    end
    if (mon_cyc < 16) ren_vec[mon_cyc[3:0]] = fifo_ren;
    mon_cyc++;
  end

  always @(negedge clk) begin
    if (clr1) begin got1_d.delete(); got1_l.delete(); end
    if (rst === 1'b0) begin
      if (out_valid1 && ready1) begin got1_d.push_back(out_data1); got1_l.push_back(out_last1); end
      if (done1) begin done1_cnt++; ab1 = aborted1; end
    end
  end

  int checks = 0, errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ref_q.delete();
  endtask

  task automatic fifo_write(input logic [W-1:0] d);
    mem[wr_ptr[9:0]] = d;
    wr_ptr++;
    ref_q.push_back(d);
  endtask

  task automatic start_burst();
    mon_clr = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != base) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({fifo_ren, out_valid, out_last, busy, done, aborted} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", {fifo_ren, out_valid, out_last, busy, done, aborted});
    end
    checks++;
    if (out_data !== 16'h0 || words_sent !== 3'd0) begin
      errors++; $display("FAIL reset_data: got data %h sent %0d expected 0 0", out_data, words_sent);
    end
    checks++;
    if ({busy1, out_valid1, fifo1_ren, ws1} !== 4'b0) begin
      errors++; $display("FAIL reset_len1: got %b expected 0000", {busy1, out_valid1, fifo1_ren, ws1});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    logic [W-1:0] exp_d[$];
    int d0;
    bit ok;
    flush_fifo();
    for (int i = 1; i <= 6; i++) fifo_write(W'(i));
    out_ready = 1'b1;
    d0 = done_cnt;
    start_burst();
    wait_done(d0, 40, ok);
    repeat (3) tick();
    for (int i = 0; i < L; i++) exp_d.push_back(ref_q.pop_front());
    checks++;
    if (!ok) begin errors++; $display("FAIL burst_timeout: got no done expected done"); end
    checks++;
    if (ren_vec !== 16'h001e) begin errors++; $display("FAIL burst_ren_pattern: got %h expected 001e", ren_vec); end
    checks++;
    if (got_d.size() != L) begin errors++; $display("FAIL burst_count: got %0d expected %0d", got_d.size(), L); end
    for (int i = 0; i < L && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == L - 1) || got_c[i] != i + 2) begin
        errors++;
        $display("FAIL burst_word%0d: got %h/%b@%0d expected %h/%b@%0d", i, got_d[i], got_l[i], got_c[i], exp_d[i], i == L - 1, i + 2);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || last_ab !== 1'b0) begin
      errors++; $display("FAIL burst_done: got %0d pulses aborted %b expected 1 pulse aborted 0", done_cnt - d0, last_ab);
    end
    checks++;
    if (words_sent !== 3'd4) begin errors++; $display("FAIL burst_words_sent: got %0d expected 4", words_sent); end
    checks++;
    if (wr_ptr - rd_ptr != ref_q.size() || fifo_rdata !== ref_q[0]) begin
      errors++; $display("FAIL burst_fifo_left: got %0d head %h expected %0d head %h", wr_ptr - rd_ptr, fifo_rdata, ref_q.size(), ref_q[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_d[$];
    int d0, r0, h0;
    bit ok;
    flush_fifo();
    for (int i = 0; i < 6; i++) fifo_write(W'($urandom));
    out_ready = 1'b0;
    d0 = done_cnt; r0 = rd_ptr; h0 = hold_viol;
    start_burst();
    repeat (5) tick();
    checks++;
    if (rd_ptr - r0 != 2 || fifo_ren !== 1'b0) begin
      errors++; $display("FAIL bp_pops: got %0d ren %b expected 2 ren 0", rd_ptr - r0, fifo_ren);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_q[0]) begin
      errors++; $display("FAIL bp_hold_head: got %b/%h expected 1/%h", out_valid, out_data, ref_q[0]);
    end
    out_ready = 1'b1;
    wait_done(d0, 40, ok);
    repeat (2) tick();
    for (int i = 0; i < L; i++) exp_d.push_back(ref_q.pop_front());
    checks++;
    if (!ok || got_d.size() != L) begin
      errors++; $display("FAIL bp_count: got done %b words %0d expected 1 %0d", ok, got_d.size(), L);
    end
    for (int i = 0; i < L && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == L - 1)) begin
        errors++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], i == L - 1);
      end
    end
    checks++;
    if (hold_viol != h0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", hold_viol - h0); end
  endtask

  task automatic test_empty_stall();
    logic [W-1:0] exp_d[$];
    int d0, e0, busy_low;
    bit ok;
    flush_fifo();
    out_ready = 1'b1;
    d0 = done_cnt; e0 = empty_viol; busy_low = 0;
    start_burst();
    for (int i = 0; i < L; i++) begin
      repeat (3) begin
        if (busy !== 1'b1) busy_low++;
        tick();
      end
      fifo_write(W'($urandom));
    end
    wait_done(d0, 20, ok);
    repeat (2) tick();
    for (int i = 0; i < L; i++) exp_d.push_back(ref_q.pop_front());
    checks++;
    if (!ok || busy_low != 0) begin errors++; $display("FAIL stall_busy: got done %b busy_low %0d expected 1 0", ok, busy_low); end
    checks++;
    if (empty_viol != e0) begin errors++; $display("FAIL stall_ren_empty: got %0d expected 0", empty_viol - e0); end
    checks++;
    if (got_d.size() != L || words_sent !== 3'd4) begin
      errors++; $display("FAIL stall_count: got %0d sent %0d expected %0d", got_d.size(), words_sent, L);
    end
    for (int i = 0; i < L && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == L - 1)) begin
        errors++; $display("FAIL stall_word%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], i == L - 1);
      end
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] exp_d[$];
    int d0, r0;
    bit ok;
    flush_fifo();
    for (int i = 0; i < 6; i++) fifo_write(W'($urandom));
    out_ready = 1'b1;
    d0 = done_cnt; r0 = rd_ptr;
    start_burst();
    for (int i = 0; i < 20 && rd_ptr - r0 < 2; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(d0, 20, ok);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) exp_d.push_back(ref_q.pop_front());
    checks++;
    if (!ok || last_ab !== 1'b1) begin errors++; $display("FAIL abort_done: got done %b aborted %b expected 1 1", ok, last_ab); end
    checks++;
    if (rd_ptr - r0 != 2 || words_sent !== 3'd2) begin
      errors++; $display("FAIL abort_counts: got pops %0d sent %0d expected 2 2", rd_ptr - r0, words_sent);
    end
    checks++;
    if (got_d.size() != 2) begin errors++; $display("FAIL abort_size: got %0d expected 2", got_d.size()); end
    for (int i = 0; i < 2 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== 1'b0) begin
        errors++; $display("FAIL abort_word%0d: got %h/%b expected %h/0", i, got_d[i], got_l[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_d[$];
    int d0, r0;
    bit ok;
    flush_fifo();
    for (int i = 0; i < 6; i++) fifo_write(W'($urandom));
    out_ready = 1'b0;
    r0 = rd_ptr;
    start_burst();
    repeat (3) tick();
    checks++;
    if (rd_ptr - r0 != 2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got pops %0d valid %b expected 2 1", rd_ptr - r0, out_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, busy, fifo_ren, out_last} !== 4'b0 || words_sent !== 3'd0) begin
      errors++; $display("FAIL rstmid_state: got %b sent %0d expected 0000 0", {out_valid, busy, fifo_ren, out_last}, words_sent);
    end
    rst = 1'b0;
    void'(ref_q.pop_front());
    void'(ref_q.pop_front());
    tick();
    out_ready = 1'b1;
    d0 = done_cnt;
    start_burst();
    wait_done(d0, 40, ok);
    repeat (2) tick();
    for (int i = 0; i < L; i++) exp_d.push_back(ref_q.pop_front());
    checks++;
    if (!ok || got_d.size() != L || words_sent !== 3'd4) begin
      errors++; $display("FAIL rstmid_rerun: got done %b words %0d sent %0d expected 1 4 4", ok, got_d.size(), words_sent);
    end
    for (int i = 0; i < L && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == L - 1)) begin
        errors++; $display("FAIL rstmid_word%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], i == L - 1);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [W-1:0] exp_d[$];
      int nwords, written, d0, e0, h0, guard;
      flush_fifo();
      nwords  = 4 + $urandom_range(0, 4);
      written = $urandom_range(0, nwords);
      for (int i = 0; i < written; i++) fifo_write(W'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      d0 = done_cnt; e0 = empty_viol; h0 = hold_viol; guard = 0;
      start_burst();
      while (done_cnt == d0 && guard < 300) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (written < nwords && $urandom_range(0, 1) == 1) begin
          fifo_write(W'($urandom));
          written++;
        end
        tick();
        guard++;
      end
      out_ready = 1'b1;
      repeat (2) tick();
      for (int i = 0; i < L; i++) exp_d.push_back(ref_q.pop_front());
      checks++;
      if (done_cnt - d0 != 1 || got_d.size() != L || words_sent !== 3'd4) begin
        errors++; $display("FAIL rand%0d_count: got done %0d words %0d sent %0d expected 1 4 4", it, done_cnt - d0, got_d.size(), words_sent);
      end
      for (int i = 0; i < L && i < got_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== (i == L - 1)) begin
          errors++; $display("FAIL rand%0d_word%0d: got %h/%b expected %h/%b", it, i, got_d[i], got_l[i], exp_d[i], i == L - 1);
        end
      end
      checks++;
      if (wr_ptr - rd_ptr != ref_q.size() || hold_viol != h0 || empty_viol != e0) begin
        errors++; $display("FAIL rand%0d_integrity: got left %0d hold %0d empty %0d expected %0d 0 0", it, wr_ptr - rd_ptr, hold_viol - h0, empty_viol - e0, ref_q.size());
      end
    end
  endtask

  task automatic test_len1();
    int d0, r0, guard;
    for (int i = 0; i < 2; i++) begin
      mem1[wr1[3:0]] = W'($urandom);
      ref1_q.push_back(mem1[wr1[3:0]]);
      wr1++;
    end
    d0 = done1_cnt; r0 = rd1;
    start1 = 1'b1; abort1 = 1'b1;
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    repeat (4) tick();
    checks++;
    if (rd1 != r0 || done1_cnt != d0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL len1_start_abort: got pops %0d dones %0d busy %b expected 0 0 0", rd1 - r0, done1_cnt - d0, busy1);
    end
    ready1 = 1'b1; clr1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0; clr1 = 1'b0;
    guard = 0;
    while (done1_cnt == d0 && guard < 20) begin tick(); guard++; end
    repeat (2) tick();
    checks++;
    if (done1_cnt - d0 != 1 || rd1 - r0 != 1 || ws1 !== 1'b1 || ab1 !== 1'b0) begin
      errors++; $display("FAIL len1_burst: got dones %0d pops %0d sent %0d ab %b expected 1 1 1 0", done1_cnt - d0, rd1 - r0, ws1, ab1);
    end
    checks++;
    if (got1_d.size() != 1) begin
      errors++; $display("FAIL len1_size: got %0d expected 1", got1_d.size());
    end else if (got1_d[0] !== ref1_q[0] || got1_l[0] !== 1'b1) begin
      errors++; $display("FAIL len1_word: got %h/%b expected %h/1", got1_d[0], got1_l[0], ref1_q[0]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; flush = 1'b0; mon_clr = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0; clr1 = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem1[i] = '0;
    test_reset();
    test_burst();
    test_backpressure();
    test_empty_stall();
    test_abort();
    test_reset_mid();
    test_random();
    test_len1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the team's FIFO read port (show-ahead rdata, ren, is_empty).
- On a start command it pops exactly BURST_LEN words from the FIFO.
- Words are presented on a valid/ready stream with out_last on the final word; a 2-entry skid buffer decouples backpressure from the FIFO.
- Sits in the read clock domain, directly on the FIFO read port.

Parameters:
WIDTH, 16, data word width; must match FIFO WIDTH
BURST_LEN, 8, words per burst; legal range 1..65535
CNT_BITS, $clog2(BURST_LEN+1), width of fetch and sent counters (derived, localparam)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
fifo_rdata  in  WIDTH  FIFO head word; valid whenever fifo_is_empty=0
fifo_is_empty  in  1  FIFO empty flag
fifo_ren  out  1  FIFO pop; head consumed at the clk edge where it is 1
start  in  1  single-cycle burst request
abort  in  1  single-cycle request to stop fetching
out_data  out  WIDTH  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  marks final word of a completed burst
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a burst finishes
aborted  out  1  qualifies done; 1 if the burst ended by abort
words_sent  out  CNT_BITS  words transferred on the stream in the current/last burst

Behaviour:
- Reset (rst=1 at posedge):
  - fifo_ren=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, aborted=0, words_sent=0.
  - State IDLE, skid emptied, fetch count=0.
  - Reset mid-burst discards skid contents; popped words are lost; the FIFO itself is untouched.
- States IDLE, RUN, DRAIN.
  - IDLE -> RUN: start=1 and abort=0. Clears fetch count and words_sent.
  - RUN -> DRAIN: fetch count reaches BURST_LEN, or abort=1.
  - DRAIN -> IDLE: skid empty. done=1 for one cycle on this transition; aborted=1 with it if abort caused the exit.
  - start while busy is ignored. abort in IDLE or DRAIN is ignored. start+abort together in IDLE: no burst.
- fifo_ren is combinational: RUN & !fifo_is_empty & (fetch<BURST_LEN) & (skid count<2) & !abort.
  - There is no out_ready -> fifo_ren path.
- Each fifo_ren edge writes fifo_rdata into the skid with a last tag = (fetch==BURST_LEN-1).
  - fetch count increments on each such edge.
- Latency: a word popped at edge N appears on out_data with out_valid=1 after edge N, i.e. 1 cycle.
- Skid:
  - 2 entries, FIFO order.
  - out_valid = count!=0; out_data and out_last come from the head entry.
  - Transfer = out_valid & out_ready; words_sent increments on each transfer.
  - Push and pop in the same cycle keep count unchanged. Sustained throughput is 1 word/cycle.
- out_data and out_last stay stable while out_valid=1 and out_ready=0.
- FIFO empty during RUN: no pop; stalls indefinitely with no timeout.
- Abort:
  - Words already in the skid are still delivered.
  - No out_last is synthesized for an aborted burst.
- BURST_LEN=1: single pop; that word carries out_last=1.
- Counters never wrap within a burst: fetch ≤ BURST_LEN and words_sent ≤ BURST_LEN.

Decomposition:
- Package fifo_burst_reader_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DRAIN (2 bits)
  - SKID_DEPTH=2
- Sub-module stream_skid2 (WIDTH+1 data incl. last tag):
  - ports: push/push_data, pop, head_data, count.
  - Synchronous active-high reset on clk/rst.
  - Instantiated once.
- Top holds the FSM, fetch counter, words_sent, and the fifo_ren/done logic.

Test Plan:
1. WIDTH=16, BURST_LEN=4, FIFO preloaded 0x0001..0x0006, out_ready=1, start pulse -> fifo_ren high 4 consecutive cycles; out_data 0x0001..0x0004 on consecutive cycles; out_last only with 0x0004; done 1 cycle with aborted=0; words_sent=4; FIFO left holding 0x0005,0x0006.
2. Same setup with out_ready=0 for 5 cycles after start -> exactly 2 pops then fifo_ren=0; out_data holds 0x0001; on release all 4 words arrive in order with no loss or duplication.
3. FIFO empty at start, words written one every 3 cycles -> fifo_ren only when fifo_is_empty=0; 4 words delivered; busy=1 throughout until done.
4. abort after 2nd pop, out_ready=1 -> no further fifo_ren; words 1-2 delivered with out_last=0; done with aborted=1; words_sent=2.
5. rst=1 mid-burst with skid holding 2 words -> next cycle out_valid=0, busy=0, fifo_ren=0, words_sent=0; a following start runs a clean full burst.
6. BURST_LEN=1 build, start and abort in the same IDLE cycle -> no pop and no done; a later start pops 1 word with out_last=1.
